// File: rtl/amm_read_issue.sv
// rtl/amm_read_issue.sv - Avalon-MM burst read issuer feeding compare descriptors under credit control
// Optional error stop: define READ_ISSUE_ERR_STOP_EN
module amm_read_issue #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 128,
    parameter int BURST_W      = 11,
    parameter int OFF_W        = 4,
    parameter int DESC_CREDITS = 4,
    parameter int WORD_CREDITS = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               test_start_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [ADDR_W-1:0]  cmd_addr_i,
    input  logic [BURST_W-2:0] cmd_words_i,
    input  logic [7:0]         cmd_ptrn_i,
    input  logic               cmd_rnd_i,
    input  logic [OFF_W-1:0]   cmd_start_off_i,
    input  logic [OFF_W-1:0]   cmd_end_off_i,
    output logic               amm_read_o,
    output logic [ADDR_W-1:0]  amm_address_o,
    output logic [BURST_W-1:0] amm_burstcount_o,
    input  logic               amm_waitrequest_i,
    input  logic               amm_readdatavalid_i,
    output logic               cmp_en_o,
    output logic [ADDR_W-1:0]  cmp_start_addr_o,
    output logic [BURST_W-2:0] cmp_words_o,
    output logic [7:0]         cmp_ptrn_o,
    output logic               cmp_rnd_o,
    output logic [OFF_W-1:0]   cmp_start_off_o,
    output logic [OFF_W-1:0]   cmp_end_off_o,
    input  logic               cmp_error_i,
    output logic               busy_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    localparam int DC_W  = $clog2(DESC_CREDITS + 1);
    localparam int WC_W  = $clog2(WORD_CREDITS + 1);
    localparam int PTR_W = (DESC_CREDITS > 1) ? $clog2(DESC_CREDITS) : 1;
    localparam int SUM_W = ((WC_W > BURST_W) ? WC_W : BURST_W) + 1;

    if (OFF_W != $clog2(DATA_W / 8)) begin : g_off_w_check
        $error("OFF_W must equal log2(DATA_W/8)");
    end

    logic [0:0]         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BURST_W-2:0] words_q, words_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [7:0]         ptrn_q, ptrn_d;
    logic               rnd_q, rnd_d;
    logic [OFF_W-1:0]   soff_q, soff_d;
    logic [OFF_W-1:0]   eoff_q, eoff_d;
    logic               hold_q, hold_d;
    logic               cmp_en_q, cmp_en_d;
    logic [DC_W-1:0]    desc_used_q, desc_used_d;
    logic [WC_W-1:0]    word_used_q, word_used_d;
    logic [BURST_W-1:0] len_fifo_q [DESC_CREDITS];
    logic [BURST_W-1:0] len_fifo_d [DESC_CREDITS];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [BURST_W-1:0] beats_q, beats_d;
    logic               busy_q, busy_d;

    logic               err_stop;
    logic               credit_ok;
    logic               accept;
    logic               ret;
    logic               last_beat;
    logic [SUM_W-1:0]   word_sum;
    logic [BURST_W-1:0] head_len;

`ifdef READ_ISSUE_ERR_STOP_EN
    logic err_seen_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_seen_q <= 1'b0;
        end else if (test_start_i) begin
            err_seen_q <= 1'b0;
        end else if (cmp_error_i) begin
            err_seen_q <= 1'b1;
        end
    end

    assign err_stop = err_seen_q | cmp_error_i;
`else
    logic unused_cmp_error;
    assign unused_cmp_error = cmp_error_i;
    assign err_stop         = 1'b0;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DESC_CREDITS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits use registered counts only; same-cycle returns are credited next cycle.
    assign word_sum  = SUM_W'(word_used_q) + SUM_W'(burst_q);
    assign credit_ok = (desc_used_q < DC_W'(DESC_CREDITS)) &&
                       (word_sum <= SUM_W'(WORD_CREDITS));

    // Once raised, the request is held through waitrequest regardless of later stops.
    assign amm_read_o  = (state_q == ST_ISSUE) && (hold_q || (credit_ok && !err_stop));
    assign accept      = amm_read_o && !amm_waitrequest_i;
    assign cmd_ready_o = (state_q == ST_IDLE) && !err_stop;

    // Beats arriving with no burst on record are stray and do not touch the counters.
    assign head_len  = len_fifo_q[rd_ptr_q];
    assign ret       = amm_readdatavalid_i && (desc_used_q != '0);
    assign last_beat = ret && ((beats_q + BURST_W'(1)) == head_len);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        words_d     = words_q;
        burst_d     = burst_q;
        ptrn_d      = ptrn_q;
        rnd_d       = rnd_q;
        soff_d      = soff_q;
        eoff_d      = eoff_q;
        hold_d      = hold_q;
        cmp_en_d    = 1'b0;
        desc_used_d = desc_used_q;
        word_used_d = word_used_q;
        len_fifo_d  = len_fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        beats_d     = beats_q;

        if (test_start_i) begin
            state_d     = ST_IDLE;
            hold_d      = 1'b0;
            desc_used_d = '0;
            word_used_d = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            beats_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        addr_d  = cmd_addr_i;
                        words_d = cmd_words_i;
                        burst_d = {1'b0, cmd_words_i} + BURST_W'(1);
                        ptrn_d  = cmd_ptrn_i;
                        rnd_d   = cmd_rnd_i;
                        soff_d  = cmd_start_off_i;
                        eoff_d  = cmd_end_off_i;
                        state_d = ST_ISSUE;
                    end
                end
                default: begin
                    if (accept) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase

            hold_d   = amm_read_o && amm_waitrequest_i;
            cmp_en_d = accept;

            if (accept) begin
                len_fifo_d[wr_ptr_q] = burst_q;
                wr_ptr_d             = ptr_inc(wr_ptr_q);
            end

            if (last_beat) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                beats_d  = '0;
            end else if (ret) begin
                beats_d = beats_q + BURST_W'(1);
            end

            desc_used_d = desc_used_q + DC_W'(accept) - DC_W'(last_beat);
            word_used_d = WC_W'(SUM_W'(word_used_q) + (accept ? SUM_W'(burst_q) : SUM_W'(0))
                                - SUM_W'(ret));
        end

        busy_d = (state_d != ST_IDLE) || (desc_used_d != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            words_q     <= '0;
            burst_q     <= '0;
            ptrn_q      <= '0;
            rnd_q       <= 1'b0;
            soff_q      <= '0;
            eoff_q      <= '0;
            hold_q      <= 1'b0;
            cmp_en_q    <= 1'b0;
            desc_used_q <= '0;
            word_used_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            beats_q     <= '0;
            busy_q      <= 1'b0;
            for (int i = 0; i < DESC_CREDITS; i++) begin
                len_fifo_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            words_q     <= words_d;
            burst_q     <= burst_d;
            ptrn_q      <= ptrn_d;
            rnd_q       <= rnd_d;
            soff_q      <= soff_d;
            eoff_q      <= eoff_d;
            hold_q      <= hold_d;
            cmp_en_q    <= cmp_en_d;
            desc_used_q <= desc_used_d;
            word_used_q <= word_used_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            beats_q     <= beats_d;
            busy_q      <= busy_d;
            len_fifo_q  <= len_fifo_d;
        end
    end

    assign amm_address_o    = addr_q;
    assign amm_burstcount_o = burst_q;
    assign cmp_en_o         = cmp_en_q;
    assign cmp_start_addr_o = addr_q;
    assign cmp_words_o      = words_q;
    assign cmp_ptrn_o       = ptrn_q;
    assign cmp_rnd_o        = rnd_q;
    assign cmp_start_off_o  = soff_q;
    assign cmp_end_off_o    = eoff_q;
    assign busy_o           = busy_q;

endmodule
